// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline writeback, memory load responses, register-file write port.
// No logic; master drives the sources and observes results, slave is the arbiter.
// Backpressure is carried by pipe_ready and mem_ready.
interface wb_port_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int DEPTH    = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                pipe_valid;
    logic [REG_ADDR-1:0] pipe_rd;
    logic [WIDTH-1:0]    pipe_data;
    logic                pipe_ready;

    logic                mem_valid;
    logic [REG_ADDR-1:0] mem_rd;
    logic [WIDTH-1:0]    mem_data;
    logic                mem_ready;

    logic                rf_we;
    logic [REG_ADDR-1:0] rf_waddr;
    logic [WIDTH-1:0]    rf_wdata;
    logic [CW-1:0]       buf_count;

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output mem_valid, mem_rd, mem_data,
        input  pipe_ready, mem_ready,
        input  rf_we, rf_waddr, rf_wdata, buf_count
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  mem_valid, mem_rd, mem_data,
        output pipe_ready, mem_ready,
        output rf_we, rf_waddr, rf_wdata, buf_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Merges pipeline writebacks and buffered load responses onto one register-file write port.
// Latency: pipeline accept -> write next cycle; load enqueue -> earliest write two cycles later.
// Backpressure: pipe_ready drops when a load is granted; mem_ready drops when the buffer is full.

module wb_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage needs no reset; count and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = store[rd_ptr];
endmodule

module wb_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 3
) (
    input logic               clk,
    input logic               reset,
    wb_port_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [REG_ADDR-1:0] rd;
        logic [WIDTH-1:0]    data;
    } wb_req_t;

    localparam int               CW       = $clog2(DEPTH) + 1;
    localparam int               AGE_W    = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    wb_req_t             mem_req;
    wb_req_t             head;
    logic [CW-1:0]       count;
    logic                head_valid;
    logic                full;
    logic                push;
    logic                buf_grant;
    logic                pipe_take;
    logic [AGE_W-1:0]    age;
    logic                rf_we_q;
    logic [REG_ADDR-1:0] rf_waddr_q;
    logic [WIDTH-1:0]    rf_wdata_q;

    assign mem_req.rd   = bus.mem_rd;
    assign mem_req.data = bus.mem_data;

    // mem_ready comes from registered count only, so the memory side never sees a pop path.
    assign full       = (count == FULL_CNT);
    assign head_valid = (count != '0);
    assign push       = bus.mem_valid && !full;
    assign buf_grant  = head_valid && (!bus.pipe_valid || full || age == AGE_MAX);
    assign pipe_take  = bus.pipe_valid && !buf_grant;

    wb_port_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (DEPTH)
    ) u_load_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (mem_req),
        .pop      (buf_grant),
        .pop_dat  (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            age <= '0;
        end else if (buf_grant || !head_valid) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + AGE_W'(1);
        end
    end

    // x0 writes are consumed and still update address/data, but never assert the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (buf_grant) begin
            rf_we_q    <= (head.rd != '0);
            rf_waddr_q <= head.rd;
            rf_wdata_q <= head.data;
        end else if (pipe_take) begin
            rf_we_q    <= (bus.pipe_rd != '0);
            rf_waddr_q <= bus.pipe_rd;
            rf_wdata_q <= bus.pipe_data;
        end else begin
            rf_we_q    <= 1'b0;
        end
    end

    assign bus.pipe_ready = !buf_grant;
    assign bus.mem_ready  = !full;
    assign bus.buf_count  = count;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes are queued with their due cycle,
// a negedge monitor compares the write port against the queue head every cycle.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    wb_port_arbiter_if #(.WIDTH(32), .REG_ADDR(5), .DEPTH(2)) bus ();

    wb_port_arbiter #(
        .WIDTH    (32),
        .REG_ADDR (5),
        .DEPTH    (2),
        .MAX_WAIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic expect_wr(input int due, input logic we, input logic [4:0] addr,
                             input logic [31:0] data);
        exp_t e;
        e.due = due; e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.mem_valid  = 1'b0; bus.mem_rd  = '0; bus.mem_data  = '0;
    endtask

    task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid = v; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_valid = v; bus.mem_rd = rd; bus.mem_data = d;
    endtask

    // Monitor: a due entry is compared field by field; otherwise no write may appear.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_we",   {31'd0, bus.rf_we}, {31'd0, e.we});
                chk("wr_addr", {27'd0, bus.rf_waddr}, {27'd0, e.addr});
                chk("wr_data", bus.rf_wdata, e.data);
            end else begin
                chk("no_write", {31'd0, bus.rf_we}, 32'd0);
            end
        end
    end

    initial begin
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_we",    {31'd0, bus.rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("rst_wdata", bus.rf_wdata, 32'd0);
        chk("rst_count", {30'd0, bus.buf_count}, 32'd0);
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        mon_en = 1'b1;
        tick();

        // Pipeline only
        for (int i = 0; i < 4; i++) begin
            drive_pipe(1'b1, 5'd5, 32'h1234);
            #1;
            chk("pipe_only_ready", {31'd0, bus.pipe_ready}, 32'd1);
            expect_wr(cyc + 1, 1'b1, 5'd5, 32'h1234);
            tick();
        end
        idle();
        tick();

        // Idle fill-in
        drive_mem(1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        chk("fill_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        idle();
        #1;
        chk("fill_count1", {30'd0, bus.buf_count}, 32'd1);
        chk("fill_pipe_ready", {31'd0, bus.pipe_ready}, 32'd0);
        expect_wr(cyc + 1, 1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        chk("fill_count0", {30'd0, bus.buf_count}, 32'd0);
        tick();

        // Age starvation: load passed over three times, forced on the fourth
        drive_mem(1'b1, 5'd9, 32'hA5A50009);
        for (int i = 0; i < 6; i++) begin
            drive_pipe(1'b1, 5'd3, 32'h3333);
            #1;
            chk("age_pipe_ready", {31'd0, bus.pipe_ready}, (i == 4) ? 32'd0 : 32'd1);
            if (i >= 1)
                chk("age_count", {30'd0, bus.buf_count}, (i == 5) ? 32'd0 : 32'd1);
            if (i == 4) expect_wr(cyc + 1, 1'b1, 5'd9, 32'hA5A50009);
            else        expect_wr(cyc + 1, 1'b1, 5'd3, 32'h3333);
            tick();
            drive_mem(1'b0, 5'd0, 32'd0);
        end
        idle();
        tick();

        // Full buffer
        drive_pipe(1'b1, 5'd4, 32'h4444);
        drive_mem(1'b1, 5'd10, 32'h00000A10);
        expect_wr(cyc + 1, 1'b1, 5'd4, 32'h4444);
        tick();
        drive_mem(1'b1, 5'd11, 32'h00000A11);
        #1;
        chk("full_ready_f1", {31'd0, bus.pipe_ready}, 32'd1);
        expect_wr(cyc + 1, 1'b1, 5'd4, 32'h4444);
        tick();
        drive_mem(1'b1, 5'd12, 32'h00000A12);
        #1;
        chk("full_count2", {30'd0, bus.buf_count}, 32'd2);
        chk("full_mem_ready0", {31'd0, bus.mem_ready}, 32'd0);
        chk("full_pipe_ready0", {31'd0, bus.pipe_ready}, 32'd0);
        expect_wr(cyc + 1, 1'b1, 5'd10, 32'h00000A10);
        tick();
        #1;
        chk("full_mem_ready1", {31'd0, bus.mem_ready}, 32'd1);
        chk("full_count1", {30'd0, bus.buf_count}, 32'd1);
        expect_wr(cyc + 1, 1'b1, 5'd4, 32'h4444);
        tick();
        drive_mem(1'b0, 5'd0, 32'd0);
        #1;
        chk("full_count2b", {30'd0, bus.buf_count}, 32'd2);
        expect_wr(cyc + 1, 1'b1, 5'd11, 32'h00000A11);
        tick();
        expect_wr(cyc + 1, 1'b1, 5'd4, 32'h4444);
        tick();
        drive_pipe(1'b0, 5'd0, 32'd0);
        expect_wr(cyc + 1, 1'b1, 5'd12, 32'h00000A12);
        tick();
        chk("full_count0", {30'd0, bus.buf_count}, 32'd0);
        idle();
        tick();

        // rd=0 with simultaneous enqueue/pop, then pipeline x0
        drive_mem(1'b1, 5'd13, 32'h00000D13);
        tick();
        drive_mem(1'b1, 5'd0, 32'h0000BAD0);
        expect_wr(cyc + 1, 1'b1, 5'd13, 32'h00000D13);
        tick();
        drive_mem(1'b0, 5'd0, 32'd0);
        #1;
        chk("simul_count", {30'd0, bus.buf_count}, 32'd1);
        expect_wr(cyc + 1, 1'b0, 5'd0, 32'h0000BAD0);
        tick();
        drive_pipe(1'b1, 5'd0, 32'h00000F0F);
        #1;
        chk("x0_pipe_ready", {31'd0, bus.pipe_ready}, 32'd1);
        expect_wr(cyc + 1, 1'b0, 5'd0, 32'h00000F0F);
        tick();
        idle();
        tick();
        chk("hold_wdata", bus.rf_wdata, 32'h00000F0F);
        chk("hold_waddr", {27'd0, bus.rf_waddr}, 32'd0);

        // Reset mid-flight with a full buffer and a pending pipeline write
        drive_pipe(1'b1, 5'd6, 32'h6666);
        drive_mem(1'b1, 5'd14, 32'h00000E14);
        expect_wr(cyc + 1, 1'b1, 5'd6, 32'h6666);
        tick();
        drive_mem(1'b1, 5'd15, 32'h00000E15);
        expect_wr(cyc + 1, 1'b1, 5'd6, 32'h6666);
        tick();
        drive_mem(1'b0, 5'd0, 32'd0);
        #1;
        chk("rst2_count2", {30'd0, bus.buf_count}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("rst2_we", {31'd0, bus.rf_we}, 32'd0);
        chk("rst2_count", {30'd0, bus.buf_count}, 32'd0);
        chk("rst2_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("rst2_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback sources:
  - the in-order pipeline writeback (the selected result of the WB mux);
  - late-returning data-memory load responses from a variable-latency memory.
- Load responses are buffered in a small FIFO and merged into the write port by a priority scheduler with an anti-starvation age counter.
- Sits between the WB stage / data-memory response channel and the register file write inputs.

Parameters:
- WIDTH, 32, data width of register write data.
- REG_ADDR, 5, register index width.
- DEPTH, 2, load-response buffer entries (power of 2, >=2).
- MAX_WAIT, 3, cycles a buffered load may be passed over before it is forced through.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- pipe_valid  input  1  pipeline has a writeback this cycle
- pipe_rd  input  REG_ADDR  pipeline destination register
- pipe_data  input  WIDTH  pipeline writeback data
- pipe_ready  output  1  pipeline writeback accepted this cycle (combinational)
- mem_valid  input  1  memory load response present
- mem_rd  input  REG_ADDR  load destination register
- mem_data  input  WIDTH  load data (already extended)
- mem_ready  output  1  buffer can accept a response (= not full; registered-state only)
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  REG_ADDR  register-file write address (registered)
- rf_wdata  output  WIDTH  register-file write data (registered)
- buf_count  output  $clog2(DEPTH)+1  buffered load count

Behaviour:
Interface:
- One clock, clk. Reset is synchronous and active-high, named reset.
- All state updates on the rising edge of clk.

Reset:
- FIFO empties; buf_count=0; age=0.
- rf_we=0, rf_waddr=0, rf_wdata=0.
- mem_ready=1 in the first cycle after reset.
- Reset asserted mid-operation discards buffered loads and any pending write; nothing is written in the cycle after reset.

Load buffer:
- Enqueue when mem_valid && mem_ready.
- mem_ready = (buf_count != DEPTH). It depends only on registered count, with no path from pop or pipe_valid.
- Response beats offered while full are not accepted; the source must hold them.
- Pointers wrap modulo DEPTH.
- Simultaneous enqueue and pop: buf_count unchanged, both pointers advance.

Grant, evaluated each cycle:
- buf_grant = head_valid && (!pipe_valid || buf_count==DEPTH || age==MAX_WAIT).
- pipe_ready = !buf_grant.
- The pipeline is accepted when pipe_ready && pipe_valid.
- When neither source is granted, nothing is written.

Age counter:
- Increments (saturating at MAX_WAIT) each cycle head_valid && !buf_grant.
- Clears to 0 on a pop and whenever the buffer is empty.

Write port, registered, one cycle after grant:
- rf_we = granted source valid && rd != 0.
- rf_waddr / rf_wdata = granted source's rd / data.
- rd==0 writes are consumed (popped/accepted) but rf_we=0. rf_waddr/rf_wdata still update.
- When rf_we=0, rf_waddr/rf_wdata hold their previous values, except on rd==0 consumption as above.

Latency:
- Pipeline accepted in cycle N → rf_we in N+1.
- Load enqueued in N → earliest pop N+1 → rf_we N+2.
- The enqueue-cycle response is never popped the same cycle; there is no bypass.

Ordering:
- Loads write in arrival order.
- Ordering between loads and pipeline writes to the same rd is not guaranteed here; hazard control upstream must prevent overlap.

Test Plan:
- Pipeline only: pipe_valid=1, rd=5, data=0x1234 every cycle, no mem → pipe_ready=1 always; rf_we=1, waddr=5, wdata=0x1234 one cycle later each cycle.
- Idle fill-in: mem response rd=7, data=0xDEADBEEF while pipe_valid=0 → enqueued cycle N, popped N+1, rf_we/waddr=7/wdata=0xDEADBEEF at N+2; buf_count 1→0.
- Age starvation: one buffered load plus pipe_valid=1 continuously, MAX_WAIT=3 → pipe_ready low exactly once, on the 4th cycle after enqueue+1; load written next cycle; age back to 0.
- Full buffer: two responses back-to-back with pipe_valid=1 → buf_count=2, mem_ready=0; a third response is held. The next cycle pops (pipe_ready=0); mem_ready=1 the following cycle and the third response enqueues. Writes are in order.
- rd=0 and simultaneous: load to x0 enqueued while another is popped → count unchanged, x0 pop gives rf_we=0; pipeline write to x0 → rf_we=0, pipe_ready=1.
- Reset mid-flight: buf_count=2, assert reset one cycle → next cycle rf_we=0, buf_count=0, mem_ready=1; no buffered data ever written.
